// File: rtl/enc_snapshot_seq.sv
// enc_snapshot_seq: latches every encoder channel on one trigger and streams
// the snapshot as a framed 32-bit valid/ready word sequence.
module enc_snapshot_seq #(
   parameter int NUM_CH = 4,
   parameter int POS_W  = 25,
   parameter int PER_W  = 16,
   parameter int FREQ_W = 16
) (
   input  logic                     sysclk,
   input  logic                     reset,
   input  logic                     trig,
   input  logic [NUM_CH*POS_W-1:0]  pos_in,
   input  logic [NUM_CH*PER_W-1:0]  per_in,
   input  logic [NUM_CH*FREQ_W-1:0] freq_in,
   output logic [31:0]              out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     out_last,
   output logic                     busy,
   output logic [7:0]               overrun_cnt,
   output logic [15:0]              seq_num
);
   localparam int NW = 3*NUM_CH + 1;
   localparam int IW = $clog2(NW);
   localparam logic [IW-1:0] LAST_IDX = IW'(3*NUM_CH);
   localparam logic IDLE   = 1'b0;
   localparam logic STREAM = 1'b1;

   logic                     state;
   logic [IW-1:0]            idx;
   logic [NUM_CH*POS_W-1:0]  pos_q;
   logic [NUM_CH*PER_W-1:0]  per_q;
   logic [NUM_CH*FREQ_W-1:0] freq_q;
   logic [31:0]              words [NW];
   logic                     last;

   // Header shows the count of frames completed before this one.
   assign words[0] = {8'hEC, 8'(NUM_CH), seq_num};
   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      assign words[1+3*k] = 32'(pos_q[k*POS_W +: POS_W]);
      assign words[2+3*k] = 32'(per_q[k*PER_W +: PER_W]);
      assign words[3+3*k] = 32'(freq_q[k*FREQ_W +: FREQ_W]);
   end

   assign last      = idx == LAST_IDX;
   assign out_valid = state == STREAM;
   assign busy      = out_valid;
   assign out_last  = out_valid & last;
   assign out_data  = out_valid ? words[idx] : 32'd0;

   always_ff @(posedge sysclk) begin
      if (!reset) begin
         state       <= IDLE;
         idx         <= '0;
         pos_q       <= '0;
         per_q       <= '0;
         freq_q      <= '0;
         overrun_cnt <= 8'd0;
         seq_num     <= 16'd0;
      end else if (state == IDLE) begin
         if (trig) begin
            pos_q  <= pos_in;
            per_q  <= per_in;
            freq_q <= freq_in;
            idx    <= '0;
            state  <= STREAM;
         end
      end else begin
         if (trig && overrun_cnt != 8'hFF)
            overrun_cnt <= overrun_cnt + 8'd1;
         if (out_ready) begin
            if (last) begin
               state   <= IDLE;
               seq_num <= seq_num + 16'd1;
            end else begin
               idx <= idx + IW'(1);
            end
         end
      end
   end
endmodule
